alu_cmd_ctrl: RTL and testbench

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

---
 rtl/alu_pkg.sv | 27 ++
 rtl/sat_cnt4.sv | 21 ++
 rtl/alu_cmd_ctrl.sv | 106 ++++++++++
 tb/tb_alu_cmd_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the ALU command controller.
package alu_pkg;

  // ALU opcodes as driven on alu_op
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_RESP    = 2'b11
  } state_t;

  // Only arithmetic opcodes produce meaningful carry/overflow flags
  function automatic logic op_has_flags(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/sat_cnt4.sv
// 4-bit up counter that sticks at 15 instead of wrapping.
module sat_cnt4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clear,
  output logic [3:0] count
);

  // Count enabled events, holding at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (en && (count != 4'hF)) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Sequences one command at a time through an external combinational ALU:
// accept, present operands, capture results, hold response until consumed.
module alu_cmd_ctrl
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  output logic [3:0] alu_num1,
  output logic [3:0] alu_num2,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_cf,
  input  logic       alu_overflow,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_cf,
  output logic       rsp_overflow,
  output logic [3:0] ovf_count
);

  state_t state_q;
  state_t state_d;
  logic   cmd_fire;
  logic   rsp_fire;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign rsp_fire = rsp_valid && rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples the pre-edge values, independent of block ordering.
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would infer a latch.
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid = 1'b1;
        // Back to IDLE only; a command waiting now is taken next cycle.
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand registers toward the ALU: load only on command acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are a handful of flops, not a memory array, so all of
      // them take the async reset to give a defined ALU input after reset.
      alu_num1 <= 4'd0;
      alu_num2 <= 4'd0;
      alu_op   <= OP_ADD;
    end else if (cmd_fire) begin
      alu_num1 <= cmd_a;
      alu_num2 <= cmd_b;
      alu_op   <= cmd_op;
    end
  end

  // Response registers: sample the ALU at the end of CAPTURE, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result   <= 4'd0;
      rsp_cf       <= 1'b0;
      rsp_overflow <= 1'b0;
    end else if (state_q == ST_CAPTURE) begin
      rsp_result   <= alu_result;
      rsp_cf       <= op_has_flags(alu_op) ? alu_cf       : 1'b0;
      rsp_overflow <= op_has_flags(alu_op) ? alu_overflow : 1'b0;
    end
  end

  // Count delivered responses that carried an overflow
  sat_cnt4 u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rsp_fire && rsp_overflow),
    .clear (1'b0),
    .count (ovf_count)
  );

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a behavioural ALU beside the DUT.
module tb_alu_cmd_ctrl;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [3:0] alu_num1;
  logic [3:0] alu_num2;
  logic [2:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_cf;
  logic       alu_overflow;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_cf;
  logic       rsp_overflow;
  logic [3:0] ovf_count;

  int total = 0;
  int bad   = 0;

  alu_cmd_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .alu_num1     (alu_num1),
    .alu_num2     (alu_num2),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .alu_cf       (alu_cf),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_cf       (rsp_cf),
    .rsp_overflow (rsp_overflow),
    .ovf_count    (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; logic ops drive dirty flags (1) so flag masking shows
  always_comb begin
    logic [4:0] wide;
    wide         = 5'd0;
    alu_result   = 4'd0;
    alu_cf       = 1'b1;
    alu_overflow = 1'b1;
    case (alu_op)
      OP_ADD: begin
        wide         = {1'b0, alu_num1} + {1'b0, alu_num2};
        alu_result   = wide[3:0];
        alu_cf       = wide[4];
        alu_overflow = (alu_num1[3] == alu_num2[3]) && (wide[3] != alu_num1[3]);
      end
      OP_SUB: begin
        wide         = {1'b0, alu_num1} - {1'b0, alu_num2};
        alu_result   = wide[3:0];
        alu_cf       = wide[4];
        alu_overflow = (alu_num1[3] != alu_num2[3]) && (wide[3] != alu_num1[3]);
      end
      OP_NOT:  alu_result = ~alu_num1;
      OP_AND:  alu_result = alu_num1 & alu_num2;
      OP_OR:   alu_result = alu_num1 | alu_num2;
      OP_XOR:  alu_result = alu_num1 ^ alu_num2;
      OP_LT:   alu_result = {3'b000, alu_num1 < alu_num2};
      default: alu_result = {3'b000, alu_num1 == alu_num2};
    endcase
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction with rsp_ready high; checks every stage
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] exp_res,
                         input logic exp_cf, input logic exp_ovf, input logic [3:0] exp_cnt);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check({tag, " issue num1"}, 8'(alu_num1), 8'(a));
    check({tag, " issue num2"}, 8'(alu_num2), 8'(b));
    check({tag, " issue op"}, 8'(alu_op), 8'(op));
    check({tag, " issue ready"}, 8'(cmd_ready), 8'd0);
    check({tag, " issue valid"}, 8'(rsp_valid), 8'd0);
    tick();
    check({tag, " capture valid"}, 8'(rsp_valid), 8'd0);
    tick();
    check({tag, " resp valid"}, 8'(rsp_valid), 8'd1);
    check({tag, " result"}, 8'(rsp_result), 8'(exp_res));
    check({tag, " cf"}, 8'(rsp_cf), 8'(exp_cf));
    check({tag, " ovf"}, 8'(rsp_overflow), 8'(exp_ovf));
    tick();
    check({tag, " idle ready"}, 8'(cmd_ready), 8'd1);
    check({tag, " idle valid"}, 8'(rsp_valid), 8'd0);
    check({tag, " ovf_count"}, 8'(ovf_count), 8'(exp_cnt));
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_ADD;
    cmd_a     = 4'd0;
    cmd_b     = 4'd0;
    rsp_ready = 1'b1;

    // Reset values
    #12;
    check("rst ready", 8'(cmd_ready), 8'd1);
    check("rst valid", 8'(rsp_valid), 8'd0);
    check("rst result", 8'(rsp_result), 8'd0);
    check("rst flags", 8'({rsp_cf, rsp_overflow}), 8'd0);
    check("rst alu", 8'({alu_num1, alu_num2}), 8'd0);
    check("rst alu_op", 8'(alu_op), 8'd0);
    check("rst ovf_count", 8'(ovf_count), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic vectors; first one accepted on the first edge after reset release
    run_cmd("add7+1", OP_ADD, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1, 4'd1);
    run_cmd("sub3-5", OP_SUB, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0, 4'd1);
    run_cmd("xor", OP_XOR, 4'b1100, 4'b1010, 4'b0110, 1'b0, 1'b0, 4'd1);
    run_cmd("addF+1", OP_ADD, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0, 4'd1);
    run_cmd("not", OP_NOT, 4'b1100, 4'b0000, 4'b0011, 1'b0, 1'b0, 4'd1);
    run_cmd("or", OP_OR, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0, 4'd1);
    run_cmd("lt", OP_LT, 4'b0010, 4'b0101, 4'b0001, 1'b0, 1'b0, 4'd1);
    run_cmd("eq", OP_EQ, 4'b0110, 4'b0101, 4'b0000, 1'b0, 1'b0, 4'd1);

    // Backpressure with cmd_valid held and operands changing
    rsp_ready = 1'b0;
    cmd_op    = OP_ADD;
    cmd_a     = 4'b0101;
    cmd_b     = 4'b0110;
    cmd_valid = 1'b1;
    tick();
    cmd_op = OP_XOR;
    cmd_a  = 4'b1001;
    cmd_b  = 4'b0011;
    tick();
    check("bp capture num1", 8'(alu_num1), 8'h5);
    check("bp capture num2", 8'(alu_num2), 8'h6);
    check("bp capture op", 8'(alu_op), 8'(OP_ADD));
    cmd_a = 4'b1110;
    tick();
    check("bp resp valid", 8'(rsp_valid), 8'd1);
    check("bp resp result", 8'(rsp_result), 8'hB);
    check("bp resp ovf", 8'(rsp_overflow), 8'd1);
    for (int i = 0; i < 5; i++) begin
      cmd_a = 4'(i);
      tick();
      check("bp hold valid", 8'(rsp_valid), 8'd1);
      check("bp hold result", 8'(rsp_result), 8'hB);
      check("bp hold ovf", 8'(rsp_overflow), 8'd1);
      check("bp hold ready", 8'(cmd_ready), 8'd0);
      check("bp hold num1", 8'(alu_num1), 8'h5);
      check("bp hold count", 8'(ovf_count), 8'd1);
    end
    // Handshake with a command already waiting: it must not be taken this edge
    rsp_ready = 1'b1;
    cmd_op    = OP_AND;
    cmd_a     = 4'b0010;
    cmd_b     = 4'b0110;
    tick();
    check("hs idle ready", 8'(cmd_ready), 8'd1);
    check("hs idle valid", 8'(rsp_valid), 8'd0);
    check("hs not same-cycle", 8'(alu_num1), 8'h5);
    check("hs count", 8'(ovf_count), 8'd2);
    tick();
    cmd_valid = 1'b0;
    check("hs next accept num1", 8'(alu_num1), 8'h2);
    check("hs next accept op", 8'(alu_op), 8'(OP_AND));
    check("hs next ready", 8'(cmd_ready), 8'd0);
    tick();
    tick();
    check("and valid", 8'(rsp_valid), 8'd1);
    check("and result", 8'(rsp_result), 8'h2);
    check("and flags masked", 8'({rsp_cf, rsp_overflow}), 8'd0);
    tick();
    check("and done", 8'(cmd_ready), 8'd1);

    // Saturation: 17 overflowing adds from a fresh reset
    rst_n = 1'b0;
    #3;
    check("sat rst count", 8'(ovf_count), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      run_cmd("sat", OP_ADD, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1,
              (i + 1 > 15) ? 4'd15 : 4'(i + 1));
    end

    // Reset during CAPTURE abandons the command
    cmd_op    = OP_ADD;
    cmd_a     = 4'b0111;
    cmd_b     = 4'b0001;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst valid", 8'(rsp_valid), 8'd0);
    check("midrst ready", 8'(cmd_ready), 8'd1);
    check("midrst count", 8'(ovf_count), 8'd0);
    check("midrst alu", 8'({alu_num1, alu_num2}), 8'd0);
    check("midrst result", 8'(rsp_result), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst no rsp", 8'(rsp_valid), 8'd0);
      check("midrst stay idle", 8'(cmd_ready), 8'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
